// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch queue.
//   fetch_entry_t  one buffered {PC, instruction} pair
//   NOP_INSTR      instruction presented to decode when the queue is empty
//   FETCH_DEPTH    default queue depth
package fetch_pkg;

    localparam int unsigned FETCH_DEPTH  = 4;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x fetch_entry_t storage for the fetch queue.
//   Clk    clock
//   we     write enable (synchronous write on posedge Clk)
//   waddr  write index
//   wdata  entry to store
//   raddr  read index (asynchronous read)
//   rdata  entry at raddr
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  fetch_entry_t       wdata,
    input  logic [PTR_W-1:0]   raddr,
    output fetch_entry_t       rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the PC/instruction memory and decode.
// Buffers {PC, instruction} pairs over valid/ready handshakes; Flush drops all entries.
//   Clk                 clock
//   Reset               synchronous active-low reset
//   Flush               discard all entries (branch/jump redirect)
//   InPC/InInstr        fetched PC and instruction
//   InValid/InReady     fetch-side handshake
//   OutPC/OutInstr      head entry (0 / NOP when empty)
//   OutValid/OutReady   decode-side handshake
//   Count               occupied entries
//   Debug               PC of most recently popped entry (only when FETCHQ_DEBUG_EN is defined)
// Optional feature macro: FETCHQ_DEBUG_EN
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = FETCH_DEPTH,
    parameter int unsigned DATA_W = FETCH_DATA_W,
    parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Flush,
    input  logic [ADDR_W-1:0]          InPC,
    input  logic [DATA_W-1:0]          InInstr,
    input  logic                       InValid,
    output logic                       InReady,
    output logic [ADDR_W-1:0]          OutPC,
    output logic [DATA_W-1:0]          OutInstr,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [$clog2(DEPTH+1)-1:0] Count
`ifdef FETCHQ_DEBUG_EN
    ,
    output logic [ADDR_W-1:0]          Debug
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;
    fetch_entry_t     wentry;
    fetch_entry_t     rentry;

    assign InReady  = (Count != CNT_W'(DEPTH));
    assign OutValid = (Count != '0);
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;

    assign wentry.pc    = InPC;
    assign wentry.instr = InInstr;

    // Writes during Flush land in a slot that is no longer counted, so no gating needed.
    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .Clk   (Clk),
        .we    (push),
        .waddr (tail),
        .wdata (wentry),
        .raddr (head),
        .rdata (rentry)
    );

    assign OutPC    = OutValid ? rentry.pc    : '0;
    assign OutInstr = OutValid ? rentry.instr : NOP_INSTR;

    always_ff @(posedge Clk) begin
        if (!Reset || Flush) begin
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   Count <= Count + CNT_W'(1);
                2'b01:   Count <= Count - CNT_W'(1);
                default: Count <= Count;
            endcase
        end
    end

`ifdef FETCHQ_DEBUG_EN
    // A pop coinciding with Flush is ignored, so it must not update Debug either.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Debug <= '0;
        end else if (pop && !Flush) begin
            Debug <= OutPC;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic        Flush;
    logic [31:0] InPC;
    logic [31:0] InInstr;
    logic        InValid;
    logic        InReady;
    logic [31:0] OutPC;
    logic [31:0] OutInstr;
    logic        OutValid;
    logic        OutReady;
    logic [2:0]  Count;
`ifdef FETCHQ_DEBUG_EN
    logic [31:0] Debug;
`endif

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (32),
        .ADDR_W (32)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Flush    (Flush),
        .InPC     (InPC),
        .InInstr  (InInstr),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutPC    (OutPC),
        .OutInstr (OutInstr),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Count    (Count)
`ifdef FETCHQ_DEBUG_EN
        ,
        .Debug    (Debug)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: FIFO of {pc, instr}, plus last popped PC.
    logic [63:0] exp_q[$];
    logic [31:0] m_debug = '0;

    function automatic int m_count();
        return exp_q.size();
    endfunction

    function automatic logic m_valid();
        return exp_q.size() != 0;
    endfunction

    function automatic logic m_ready();
        return exp_q.size() < DEPTH;
    endfunction

    function automatic logic [31:0] m_pc();
        logic [63:0] e;
        if (exp_q.size() == 0) return 32'h0;
        e = exp_q[0];
        return e[63:32];
    endfunction

    function automatic logic [31:0] m_instr();
        logic [63:0] e;
        if (exp_q.size() == 0) return 32'h0;
        e = exp_q[0];
        return e[31:0];
    endfunction

    // Advance one clock edge, updating the model from the inputs present at that edge.
    task automatic tick();
        logic do_push;
        logic do_pop;
        logic [31:0] head_pc;
        do_push = InValid && m_ready();
        do_pop  = OutReady && m_valid();
        head_pc = m_pc();
        @(posedge Clk);
        if (!Reset) begin
            exp_q.delete();
            m_debug = '0;
        end else if (Flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                m_debug = head_pc;
                void'(exp_q.pop_front());
            end
            if (do_push) exp_q.push_back({InPC, InInstr});
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        InPC = '0; InInstr = '0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        checks++; if (Count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
        checks++; if (OutValid !== 1'b0)  begin errors++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
        checks++; if (InReady !== 1'b1)   begin errors++; $display("FAIL reset_inready: got %b expected 1", InReady); end
        checks++; if (OutPC !== 32'h0)    begin errors++; $display("FAIL reset_outpc: got %h expected 0", OutPC); end
        checks++; if (OutInstr !== 32'h0) begin errors++; $display("FAIL reset_outinstr: got %h expected 0", OutInstr); end
    endtask

    task automatic test_fill();
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1;
            InPC    = 32'(i * 4);
            InInstr = $urandom;
            tick();
        end
        checks++; if (Count !== 3'd4)   begin errors++; $display("FAIL fill_count: got %0d expected 4", Count); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL fill_inready: got %b expected 0", InReady); end
        checks++; if (OutPC !== 32'h0)  begin errors++; $display("FAIL fill_outpc: got %h expected 0", OutPC); end
        InPC = 32'h10;
        InInstr = $urandom;
        tick();
        checks++; if (Count !== 3'd4)   begin errors++; $display("FAIL full_push_count: got %0d expected 4", Count); end
        checks++; if (OutPC !== 32'h0)  begin errors++; $display("FAIL full_push_outpc: got %h expected 0", OutPC); end
        checks++; if (OutInstr !== m_instr()) begin errors++; $display("FAIL full_push_outinstr: got %h expected %h", OutInstr, m_instr()); end
        InValid = 1'b0;
    endtask

    task automatic test_drain_wrap();
        logic [31:0] pc;
        logic [31:0] seen[$];
        logic        acc;
        pc = 32'h10;
        OutReady = 1'b1;
        for (int c = 0; c < 14; c++) begin
            InValid = 1'b1;
            InPC    = pc;
            InInstr = ~pc;
            acc     = m_ready();
            if (m_valid()) seen.push_back(OutPC);
            tick();
            if (acc) pc = pc + 32'h4;
            checks++; if (Count !== 3'(m_count())) begin errors++; $display("FAIL drain_count: got %0d expected %0d", Count, m_count()); end
            checks++; if (Count > 3'd4)            begin errors++; $display("FAIL drain_count_max: got %0d expected <=4", Count); end
            checks++; if (OutPC !== m_pc())        begin errors++; $display("FAIL drain_outpc: got %h expected %h", OutPC, m_pc()); end
        end
        for (int k = 0; k < seen.size(); k++) begin
            checks++;
            if (seen[k] !== 32'(k * 4)) begin
                errors++; $display("FAIL drain_order[%0d]: got %h expected %h", k, seen[k], 32'(k * 4));
            end
        end
        InValid = 1'b0;
    endtask

    task automatic test_flush();
        for (int n = 3; n <= 4; n++) begin
            Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
            tick();
            Reset = 1'b1;
            for (int i = 0; i < n; i++) begin
                InValid = 1'b1; InPC = 32'h100 + 32'(i * 4); InInstr = $urandom;
                tick();
            end
            checks++; if (Count !== 3'(n)) begin errors++; $display("FAIL flush_pre_count: got %0d expected %0d", Count, n); end
            Flush = 1'b1; InValid = 1'b1; InPC = 32'h40; InInstr = 32'hdead_beef; OutReady = 1'b1;
            tick();
            Flush = 1'b0; InValid = 1'b0;
            checks++; if (Count !== 3'd0)    begin errors++; $display("FAIL flush_count: got %0d expected 0", Count); end
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_outvalid: got %b expected 0", OutValid); end
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (OutValid !== 1'b0 || OutPC === 32'h40) begin
                    errors++; $display("FAIL flush_leak: got valid=%b pc=%h expected valid=0", OutValid, OutPC);
                end
            end
        end
    endtask

    task automatic test_bypass();
        InValid = 1'b1; InPC = 32'h20; InInstr = 32'h2008_0005; OutReady = 1'b1;
        #1;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bypass_pre_valid: got %b expected 0", OutValid); end
        tick();
        InValid = 1'b0;
        checks++; if (OutValid !== 1'b1)          begin errors++; $display("FAIL bypass_valid: got %b expected 1", OutValid); end
        checks++; if (OutPC !== 32'h20)           begin errors++; $display("FAIL bypass_pc: got %h expected 00000020", OutPC); end
        checks++; if (OutInstr !== 32'h2008_0005) begin errors++; $display("FAIL bypass_instr: got %h expected 20080005", OutInstr); end
        checks++; if (Count !== 3'd1)             begin errors++; $display("FAIL bypass_count: got %0d expected 1", Count); end
        tick();
        checks++; if (Count !== 3'd0)    begin errors++; $display("FAIL bypass_pop_count: got %0d expected 0", Count); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bypass_pop_valid: got %b expected 0", OutValid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            InValid  = 1'($urandom_range(0, 3) != 0);
            OutReady = 1'($urandom_range(0, 2) != 0);
            Flush    = 1'($urandom_range(0, 24) == 0);
            Reset    = 1'($urandom_range(0, 59) != 0);
            InPC     = $urandom;
            InInstr  = $urandom;
            tick();
            checks++; if (Count !== 3'(m_count()))  begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, Count, m_count()); end
            checks++; if (OutValid !== m_valid())   begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, OutValid, m_valid()); end
            checks++; if (InReady !== m_ready())    begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, InReady, m_ready()); end
            checks++; if (OutPC !== m_pc())         begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", c, OutPC, m_pc()); end
            checks++; if (OutInstr !== m_instr())   begin errors++; $display("FAIL rand_instr[%0d]: got %h expected %h", c, OutInstr, m_instr()); end
`ifdef FETCHQ_DEBUG_EN
            checks++; if (Debug !== m_debug)        begin errors++; $display("FAIL rand_debug[%0d]: got %h expected %h", c, Debug, m_debug); end
`endif
        end
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    endtask

`ifdef FETCHQ_DEBUG_EN
    task automatic test_debug();
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            InValid = 1'b1; InPC = 32'(i * 4); InInstr = $urandom;
            tick();
        end
        InValid = 1'b0; OutReady = 1'b1;
        tick();
        tick();
        OutReady = 1'b0;
        checks++; if (Debug !== 32'h4) begin errors++; $display("FAIL debug_pop: got %h expected 00000004", Debug); end
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++; if (Debug !== 32'h4) begin errors++; $display("FAIL debug_flush: got %h expected 00000004", Debug); end
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        checks++; if (Debug !== 32'h0) begin errors++; $display("FAIL debug_reset: got %h expected 0", Debug); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_flush();
        test_bypass();
        test_random();
`ifdef FETCHQ_DEBUG_EN
        test_debug();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
